// File: rtl/des_key_schedule_pkg.sv
// -----------------------------------------------------------------------------
// des_key_pkg
//   Shared DES key-schedule definitions: PC1/PC2 permutation tables, the
//   per-round left-rotation schedule, FSM state type and helper functions that
//   apply the permutations. Table entries use DES bit numbering (bit 1 = MSB).
// -----------------------------------------------------------------------------
package des_key_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PC1  = 2'd1,
        GEN  = 2'd2,
        DONE = 2'd3
    } ks_state_t;

    typedef logic [47:0] subkey_t;
    typedef logic [55:0] cd_t;

    localparam logic [5:0] PC1_TAB [56] = '{
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
        6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
        6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
        6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
        6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
        6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
        6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
        6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
    };

    localparam logic [5:0] PC2_TAB [48] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    // Left-rotate amount per round; the amounts sum to 28 so C/D wrap fully.
    localparam logic [1:0] SHIFT_SCHED [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // DES bit n of a 64-bit word lives at vector index 64-n, i.e. 63-(n-1).
    function automatic cd_t pc1_perm(input logic [63:0] key);
        cd_t cd;
        cd = '0;
        for (int i = 0; i < 56; i++) begin
            cd[55 - i] = key[6'd63 - (PC1_TAB[i] - 6'd1)];
        end
        return cd;
    endfunction

    function automatic subkey_t pc2_perm(input cd_t cd);
        subkey_t sk;
        sk = '0;
        for (int i = 0; i < 48; i++) begin
            sk[47 - i] = cd[6'd55 - (PC2_TAB[i] - 6'd1)];
        end
        return sk;
    endfunction

endpackage

// File: rtl/des_key_schedule_chk.sv
// -----------------------------------------------------------------------------
// des_key_schedule_chk
//   Protocol checks for the key schedule: the fixed round count, the full
//   28-bit wrap of C/D after the last round, and single-cycle load_done.
// Ports
//   clk, rst       clock and synchronous active-high reset
//   wrap_check_i   high in the cycle that computes the last subkey
//   cd_final_i     rotated {C,D} of that cycle
//   cd_ref_i       PC1 of the key being scheduled
//   load_done_i    completion pulse
// -----------------------------------------------------------------------------
module des_key_schedule_chk
    import des_key_pkg::*;
#(
    parameter int ROUNDS = 16
) (
    input logic clk,
    input logic rst,
    input logic wrap_check_i,
    input cd_t  cd_final_i,
    input cd_t  cd_ref_i,
    input logic load_done_i
);

    a_rounds_fixed: assert property (@(posedge clk) ROUNDS == 32'sd16);

    a_cd_wrap: assert property (@(posedge clk) disable iff (rst)
        wrap_check_i |-> (cd_final_i == cd_ref_i));

    a_done_pulse: assert property (@(posedge clk) disable iff (rst)
        load_done_i |=> !load_done_i);

endmodule

// File: rtl/des_key_schedule_key_round_step.sv
// -----------------------------------------------------------------------------
// key_round_step
//   One key-schedule step: rotates C and D (28 bits each) left by 1 or 2 and
//   produces the PC2 subkey of the rotated pair. Purely combinational.
// Ports
//   cd_i      in  56  {C,D} before rotation
//   shift_i   in  2   rotate amount (1 or 2)
//   cd_o      out 56  rotated {C,D}
//   subkey_o  out 48  PC2 of rotated {C,D}
// -----------------------------------------------------------------------------
module key_round_step
    import des_key_pkg::*;
(
    input  cd_t        cd_i,
    input  logic [1:0] shift_i,
    output cd_t        cd_o,
    output subkey_t    subkey_o
);

    logic [27:0] c_s;
    logic [27:0] d_s;

    // Rotate both halves independently, then permute for the subkey.
    always_comb begin
        c_s = cd_i[55:28];
        d_s = cd_i[27:0];
        if (shift_i == 2'd2) begin
            c_s = {c_s[25:0], c_s[27:26]};
            d_s = {d_s[25:0], d_s[27:26]};
        end else begin
            c_s = {c_s[26:0], c_s[27]};
            d_s = {d_s[26:0], d_s[27]};
        end
        cd_o     = {c_s, d_s};
        subkey_o = pc2_perm({c_s, d_s});
    end

endmodule

// File: rtl/des_key_schedule.sv
// -----------------------------------------------------------------------------
// des_key_schedule
//   Multi-slot DES key schedule. A load runs PC1 once, then one rotate+PC2
//   step per cycle, storing all 16 subkeys of the slot. A registered read port
//   returns any subkey in encrypt or decrypt order with 1-cycle latency.
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   load_key/load_sel/key_in  load strobe, destination slot, raw 64-bit key
//   busy/load_done/load_err   status: generating, completion pulse, reject pulse
//   key_valid                 per-slot schedule-complete flags
//   rd_sel/rd_round/rd_decrypt read request (slot, logical round, order)
//   rd_subkey/rd_valid        registered read data and its slot-valid flag
// -----------------------------------------------------------------------------
module des_key_schedule
    import des_key_pkg::*;
#(
    parameter  int NUM_KEYS = 3,
    parameter  int ROUNDS   = 16,
    localparam int SLOT_W   = (NUM_KEYS > 32'sd1) ? $clog2(NUM_KEYS) : 32'sd1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_key,
    input  logic [SLOT_W-1:0]   load_sel,
    input  logic [63:0]         key_in,
    output logic                busy,
    output logic                load_done,
    output logic                load_err,
    output logic [NUM_KEYS-1:0] key_valid,
    input  logic [SLOT_W-1:0]   rd_sel,
    input  logic [3:0]          rd_round,
    input  logic                rd_decrypt,
    output logic [47:0]         rd_subkey,
    output logic                rd_valid
);

    localparam logic [SLOT_W:0] NUM_KEYS_L = (SLOT_W + 1)'(NUM_KEYS);

    ks_state_t           state_q;
    logic [SLOT_W-1:0]   slot_q;
    logic [3:0]          cnt_q;
    cd_t                 cd_q;
    logic [63:0]         key_q;
    logic                busy_q;
    logic                load_done_q;
    logic                load_err_q;
    logic [NUM_KEYS-1:0] key_valid_q;
    subkey_t             rd_subkey_q;
    logic                rd_valid_q;
    subkey_t             mem_q [NUM_KEYS][ROUNDS];

    cd_t        cd_step_s;
    subkey_t    subkey_step_s;
    logic       load_ok_s;
    logic       rd_sel_ok_s;
    logic [3:0] rd_idx_s;

    assign load_ok_s   = (state_q == IDLE) && ({1'b0, load_sel} < NUM_KEYS_L);
    assign rd_sel_ok_s = ({1'b0, rd_sel} < NUM_KEYS_L);
    assign rd_idx_s    = rd_decrypt ? (4'd15 - rd_round) : rd_round;

    key_round_step u_step (
        .cd_i     (cd_q),
        .shift_i  (SHIFT_SCHED[cnt_q]),
        .cd_o     (cd_step_s),
        .subkey_o (subkey_step_s)
    );

    // Schedule FSM with its registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            slot_q      <= '0;
            cnt_q       <= 4'd0;
            busy_q      <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            key_valid_q <= '0;
        end else begin
            load_done_q <= 1'b0;
            load_err_q  <= load_key && !load_ok_s;
            case (state_q)
                IDLE: begin
                    if (load_key && load_ok_s) begin
                        slot_q                <= load_sel;
                        key_q                 <= key_in;
                        key_valid_q[load_sel] <= 1'b0;
                        busy_q                <= 1'b1;
                        state_q               <= PC1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                PC1: begin
                    cd_q    <= pc1_perm(key_q);
                    cnt_q   <= 4'd0;
                    state_q <= GEN;
                end
                GEN: begin
                    cd_q  <= cd_step_s;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_q <= DONE;
                    end else begin
                        state_q <= GEN;
                    end
                end
                DONE: begin
                    load_done_q         <= 1'b1;
                    key_valid_q[slot_q] <= 1'b1;
                    busy_q              <= 1'b0;
                    state_q             <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Subkey write port; suppressed under reset so an aborted schedule stops at once.
    always_ff @(posedge clk) begin
        if (!rst && (state_q == GEN)) begin
            mem_q[slot_q][cnt_q] <= subkey_step_s;
        end
    end

    // Registered read port; out-of-range slots read as zero and invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_subkey_q <= '0;
            rd_valid_q  <= 1'b0;
        end else if (rd_sel_ok_s) begin
            rd_subkey_q <= mem_q[rd_sel][rd_idx_s];
            rd_valid_q  <= key_valid_q[rd_sel];
        end else begin
            rd_subkey_q <= '0;
            rd_valid_q  <= 1'b0;
        end
    end

    assign busy      = busy_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;
    assign key_valid = key_valid_q;
    assign rd_subkey = rd_subkey_q;
    assign rd_valid  = rd_valid_q;

    des_key_schedule_chk #(.ROUNDS(ROUNDS)) u_chk (
        .clk          (clk),
        .rst          (rst),
        .wrap_check_i ((state_q == GEN) && (cnt_q == 4'd15)),
        .cd_final_i   (cd_step_s),
        .cd_ref_i     (pc1_perm(key_q)),
        .load_done_i  (load_done_q)
    );

endmodule
